// File: rtl/uart_nibble_tx_fifo_pkg.sv
// Shared mode encodings and framer state type for the nibble-loaded UART transmitter.
package uart_tx_pkg;

   localparam logic [1:0] MODE_IDLE     = 2'b00;
   localparam logic [1:0] MODE_LOAD_LSB = 2'b01;
   localparam logic [1:0] MODE_LOAD_MSB = 2'b10;
   localparam logic [1:0] MODE_SEND     = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } tx_state_t;

endpackage

// File: rtl/uart_nibble_tx_fifo_fifo.sv
// Small synchronous FIFO; head entry is visible on o_rdata so a pop can consume it same-cycle.
module tx_byte_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_wdata,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_rdata,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_level
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_do_push;
   logic             w_do_pop;

   assign o_full    = (r_count == (AW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign o_level   = r_count;
   assign o_rdata   = r_mem[r_rd_ptr];
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;

   always_ff @(posedge clk) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= i_wdata;
   end

   // Power-of-two depth lets the pointers wrap by natural overflow.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)
            r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_nibble_tx_fifo.sv
// Nibble-loaded byte FIFO feeding a back-to-back UART framer.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits.
module uart_nibble_tx_fifo
   import uart_tx_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int BAUD_DIV   = 256,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [3:0]                    data_pins,
   input  logic [1:0]                    mode,
   output logic                          uart_tx,
   output logic                          busy,
   output logic                          fifo_empty,
   output logic                          fifo_full,
   output logic                          overflow,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
   localparam int             BW        = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam logic [BW-1:0]  BAUD_MAX  = BW'(BAUD_DIV - 1);
   localparam logic [2:0]     LAST_DATA = 3'(DATA_BITS - 1);
   localparam logic [2:0]     LAST_STOP = 3'(STOP_BITS - 1);

   logic [1:0]           r_mode_q;
   logic [3:0]           r_lsb;
   logic                 r_overflow;
   tx_state_t            r_state;
   tx_state_t            w_state_next;
   logic [BW-1:0]        r_baud_cnt;
   logic [BW-1:0]        w_baud_next;
   logic [2:0]           r_bit_cnt;
   logic [2:0]           w_bit_next;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] w_shift_next;
`ifdef UART_TX_PARITY_EN
   logic                 r_parity;
   logic                 w_parity_next;
`endif
   logic [7:0]           w_head;
   logic                 w_push_req;
   logic                 w_pop;
   logic                 w_bnd;
   logic                 w_last_stop;

   assign w_push_req  = (mode == MODE_LOAD_MSB) && (r_mode_q != MODE_LOAD_MSB);
   assign w_bnd       = (r_baud_cnt == '0);
   assign w_last_stop = (r_state == ST_STOP) && w_bnd && (r_bit_cnt == LAST_STOP);
   // Popping in the final stop cycle is what makes frames abut with no idle bits.
   assign w_pop       = (mode == MODE_SEND) && !fifo_empty &&
                        ((r_state == ST_IDLE) || w_last_stop);
   assign busy        = (r_state != ST_IDLE);
   assign overflow    = r_overflow;

   tx_byte_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push_req),
      .i_wdata ({data_pins, r_lsb}),
      .i_pop   (w_pop),
      .o_rdata (w_head),
      .o_full  (fifo_full),
      .o_empty (fifo_empty),
      .o_level (fifo_level)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_mode_q   <= MODE_IDLE;
         r_lsb      <= '0;
         r_overflow <= 1'b0;
      end else begin
         r_mode_q <= mode;
         if (mode == MODE_LOAD_LSB)
            r_lsb <= data_pins;
         if (mode == MODE_IDLE)
            r_overflow <= 1'b0;
         else if (w_push_req && fifo_full)
            r_overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_baud_cnt <= BAUD_MAX;
         r_bit_cnt  <= '0;
         r_shift    <= '0;
`ifdef UART_TX_PARITY_EN
         r_parity   <= 1'b0;
`endif
      end else begin
         r_state    <= w_state_next;
         r_baud_cnt <= w_baud_next;
         r_bit_cnt  <= w_bit_next;
         r_shift    <= w_shift_next;
`ifdef UART_TX_PARITY_EN
         r_parity   <= w_parity_next;
`endif
      end
   end

   always_comb begin
      w_state_next  = r_state;
      w_baud_next   = w_bnd ? BAUD_MAX : r_baud_cnt - 1'b1;
      w_bit_next    = r_bit_cnt;
      w_shift_next  = r_shift;
`ifdef UART_TX_PARITY_EN
      w_parity_next = r_parity;
`endif
      if (w_pop) begin
         w_state_next  = ST_START;
         w_baud_next   = BAUD_MAX;
         w_bit_next    = '0;
         w_shift_next  = w_head[DATA_BITS-1:0];
`ifdef UART_TX_PARITY_EN
         w_parity_next = ^w_head[DATA_BITS-1:0];
`endif
      end else begin
         case (r_state)
            ST_IDLE: w_baud_next = BAUD_MAX;
            ST_START: if (w_bnd) begin
               w_state_next = ST_DATA;
               w_bit_next   = '0;
            end
            ST_DATA: if (w_bnd) begin
               w_shift_next = r_shift >> 1;
               if (r_bit_cnt == LAST_DATA) begin
`ifdef UART_TX_PARITY_EN
                  w_state_next = ST_PARITY;
`else
                  w_state_next = ST_STOP;
`endif
                  w_bit_next   = '0;
               end else begin
                  w_bit_next = r_bit_cnt + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: if (w_bnd) begin
               w_state_next = ST_STOP;
               w_bit_next   = '0;
            end
`endif
            ST_STOP: if (w_bnd) begin
               if (r_bit_cnt == LAST_STOP)
                  w_state_next = ST_IDLE;
               else
                  w_bit_next = r_bit_cnt + 1'b1;
            end
            default: w_state_next = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      uart_tx = 1'b1;
      case (r_state)
         ST_START:  uart_tx = 1'b0;
         ST_DATA:   uart_tx = r_shift[0];
`ifdef UART_TX_PARITY_EN
         ST_PARITY: uart_tx = r_parity;
`endif
         default:   uart_tx = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_uart_nibble_tx_fifo.sv
// Directed bench for uart_nibble_tx_fifo at BAUD_DIV=4, 8 data bits, 1 stop bit, 4-deep FIFO.
module tb_uart_nibble_tx_fifo;
   import uart_tx_pkg::*;

   localparam int BAUD = 4;
`ifdef UART_TX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int FRAME_BITS = 1 + 8 + PAR + 1;

   logic       clk = 1'b0;
   logic       reset;
   logic [3:0] data_pins;
   logic [1:0] mode;
   logic       uart_tx;
   logic       busy;
   logic       fifo_empty;
   logic       fifo_full;
   logic       overflow;
   logic [2:0] fifo_level;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_bytes [8];

   typedef struct {
      logic [1:0] mode;
      logic [3:0] data;
      logic [2:0] level;
      logic       full;
      logic       empty;
      logic       ovf;
   } vec_t;
   vec_t vecs [10];

   uart_nibble_tx_fifo #(
      .DATA_BITS  (8),
      .BAUD_DIV   (BAUD),
      .STOP_BITS  (1),
      .FIFO_DEPTH (4)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .data_pins  (data_pins),
      .mode       (mode),
      .uart_tx    (uart_tx),
      .busy       (busy),
      .fifo_empty (fifo_empty),
      .fifo_full  (fifo_full),
      .overflow   (overflow),
      .fifo_level (fifo_level)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [1:0] m, input logic [3:0] d);
      mode      = m;
      data_pins = d;
      tick();
   endtask

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic exp_bit(input logic [7:0] b, input int idx);
      if (idx == 0)
         return 1'b0;
      else if (idx <= 8)
         return b[idx-1];
      else if (PAR == 1 && idx == 9)
         return ^b;
      else
         return 1'b1;
   endfunction

   // Precondition: sampling #1 after the pop edge. idle_at < 0 keeps mode untouched.
   task automatic check_frames(input int n, input int idle_at);
      int cyc = 0;
      for (int f = 0; f < n; f++) begin
         int errs = 0;
         for (int bi = 0; bi < FRAME_BITS; bi++) begin
            for (int c = 0; c < BAUD; c++) begin
               if (cyc == idle_at)
                  mode = MODE_IDLE;
               if (uart_tx !== exp_bit(exp_bytes[f], bi) || busy !== 1'b1)
                  errs++;
               cyc++;
               tick();
            end
         end
         $display("[TB] frame %0d byte 0x%02h: %0d bad line/busy samples", f, exp_bytes[f], errs);
         check("frame_line", errs, 0);
      end
   endtask

   initial begin
      int errs;
      int cnt;
      logic bit9;

      reset = 1'b1;
      mode = MODE_IDLE;
      data_pins = 4'h0;
      tick();
      check("rst_tx", uart_tx, 1);
      check("rst_busy", busy, 0);
      reset = 1'b0;
      repeat (10) tick();
      check("idle_tx", uart_tx, 1);
      check("idle_busy", busy, 0);
      check("idle_empty", fifo_empty, 1);
      check("idle_level", fifo_level, 0);
      check("idle_ovf", overflow, 0);

      // Single 0xA5 frame; busy must drop exactly after 40 cycles.
      drive(MODE_LOAD_LSB, 4'h5);
      drive(MODE_LOAD_MSB, 4'hA);
      check("a5_level", fifo_level, 1);
      check("a5_busy_pre", busy, 0);
      mode = MODE_SEND;
      tick();
      exp_bytes[0] = 8'hA5;
      check_frames(1, -1);
      check("a5_busy_post", busy, 0);
      check("a5_tx_post", uart_tx, 1);
      check("a5_empty", fifo_empty, 1);
      drive(MODE_IDLE, 4'h0);

      // Holding LOAD_MSB_PUSH pushes once only.
      drive(MODE_LOAD_LSB, 4'h1);
      mode = MODE_LOAD_MSB;
      data_pins = 4'h2;
      repeat (6) tick();
      $display("[TB] held LOAD_MSB 6 cycles, level=%0d", fifo_level);
      check("hold_msb_level", fifo_level, 1);
      reset = 1'b1;
      drive(MODE_IDLE, 4'h0);
      reset = 1'b0;
      check("rst_discard", fifo_level, 0);

      // Fill to full, then overflow on the fifth push.
      vecs[0] = '{MODE_LOAD_LSB, 4'h1, 3'd0, 1'b0, 1'b1, 1'b0};
      vecs[1] = '{MODE_LOAD_MSB, 4'h1, 3'd1, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{MODE_LOAD_LSB, 4'h2, 3'd1, 1'b0, 1'b0, 1'b0};
      vecs[3] = '{MODE_LOAD_MSB, 4'h2, 3'd2, 1'b0, 1'b0, 1'b0};
      vecs[4] = '{MODE_LOAD_LSB, 4'h3, 3'd2, 1'b0, 1'b0, 1'b0};
      vecs[5] = '{MODE_LOAD_MSB, 4'h3, 3'd3, 1'b0, 1'b0, 1'b0};
      vecs[6] = '{MODE_LOAD_LSB, 4'h4, 3'd3, 1'b0, 1'b0, 1'b0};
      vecs[7] = '{MODE_LOAD_MSB, 4'h4, 3'd4, 1'b1, 1'b0, 1'b0};
      vecs[8] = '{MODE_LOAD_LSB, 4'h5, 3'd4, 1'b1, 1'b0, 1'b0};
      vecs[9] = '{MODE_LOAD_MSB, 4'h5, 3'd4, 1'b1, 1'b0, 1'b1};
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].mode, vecs[i].data);
         $display("[TB] vec %0d mode=%0d data=%0h level=%0d full=%0b empty=%0b ovf=%0b",
                  i, vecs[i].mode, vecs[i].data, fifo_level, fifo_full, fifo_empty, overflow);
         check("vec_level", fifo_level, vecs[i].level);
         check("vec_full", fifo_full, vecs[i].full);
         check("vec_empty", fifo_empty, vecs[i].empty);
         check("vec_ovf", overflow, vecs[i].ovf);
      end
      mode = MODE_SEND;
      tick();
      exp_bytes[0] = 8'h11;
      exp_bytes[1] = 8'h22;
      exp_bytes[2] = 8'h33;
      exp_bytes[3] = 8'h44;
      check_frames(4, -1);
      check("b2b_busy_post", busy, 0);
      check("b2b_tx_post", uart_tx, 1);
      check("b2b_level", fifo_level, 0);
      check("b2b_ovf_sticky", overflow, 1);
      drive(MODE_IDLE, 4'h0);
      check("idle_clears_ovf", overflow, 0);

      // Leave SEND 10 cycles into the first of two frames.
      drive(MODE_LOAD_LSB, 4'hC);
      drive(MODE_LOAD_MSB, 4'h3);
      drive(MODE_LOAD_LSB, 4'h3);
      drive(MODE_LOAD_MSB, 4'hC);
      mode = MODE_SEND;
      tick();
      exp_bytes[0] = 8'h3C;
      check_frames(1, 10);
      check("stop_send_level", fifo_level, 1);
      check("stop_send_busy", busy, 0);
      errs = 0;
      for (int i = 0; i < 20; i++) begin
         if (uart_tx !== 1'b1 || busy !== 1'b0)
            errs++;
         tick();
      end
      $display("[TB] 20 idle cycles after SEND released, %0d bad", errs);
      check("stop_send_line_high", errs, 0);

      // Reset in the middle of data bit 2 with one more byte still queued.
      drive(MODE_LOAD_LSB, 4'hF);
      drive(MODE_LOAD_MSB, 4'h0);
      mode = MODE_SEND;
      tick();
      repeat (3 * BAUD) tick();
      check("mid_busy_pre", busy, 1);
      reset = 1'b1;
      mode = MODE_IDLE;
      tick();
      reset = 1'b0;
      $display("[TB] reset mid-frame tx=%0b busy=%0b empty=%0b", uart_tx, busy, fifo_empty);
      check("mid_rst_tx", uart_tx, 1);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_empty", fifo_empty, 1);
      check("mid_rst_level", fifo_level, 0);

      // 0x07: bit 9 is parity (1) with the feature, stop (1) without; frame length differs.
      drive(MODE_LOAD_LSB, 4'h7);
      drive(MODE_LOAD_MSB, 4'h0);
      mode = MODE_SEND;
      tick();
      cnt = 0;
      bit9 = 1'b0;
      while (busy === 1'b1 && cnt < 200) begin
         if (cnt == 9 * BAUD + 2)
            bit9 = uart_tx;
         cnt++;
         tick();
      end
      $display("[TB] frame 0x07 busy for %0d cycles, bit9=%0b", cnt, bit9);
`ifdef UART_TX_PARITY_EN
      check("par_frame_len", cnt, 44);
`else
      check("frame_len", cnt, 40);
`endif
      check("bit9_line", bit9, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
